axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
AXI4-lite single-outstanding master that converts a simple command/response interface into AXI-lite write (AW/W/B) and read (AR/R) transactions. It sits directly upstream of the axi_slave memory block and drives its AXI-lite ports. The block serialises one transaction at a time, rejects misaligned addresses locally, and recovers from a hung slave with a per-phase timeout.

Parameters:
ADDR_W, 32, address width of cmd_addr and AWADDR/ARADDR
DATA_W, 32, data width of cmd_wdata, rsp_rdata, WDATA, RDATA
TIMEOUT_CYCLES, 16, cycles to wait in any AXI wait state before aborting; legal range 2..255
ERR_DATA, 32'hDEAD_BEEF, value returned on rsp_rdata for any errored response

Ports:
ACLK  in  1  clock, all logic on the rising edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address; must be word-aligned
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; ERR_DATA on error; 0 for a successful write
rsp_err  out  1  1 = misaligned address or timeout
AWADDR  out  ADDR_W  write address
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
WDATA  out  DATA_W  write data
WVALID  out  1  write data valid
WREADY  in  1  write data ready
BVALID  in  1  write response valid
BREADY  out  1  write response ready
ARADDR  out  ADDR_W  read address
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  DATA_W  read data
RVALID  in  1  read data valid
RREADY  out  1  read data ready

Behaviour:
- Reset (asynchronous, ARESETn low): state = IDLE. All outputs are 0: cmd_ready, rsp_valid, rsp_err, rsp_rdata, all VALIDs, BREADY, RREADY, and all address/data outputs. Reset mid-transaction abandons the transaction immediately and produces no response.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE: cmd_ready = 1 (registered; it is 1 only in IDLE). On acceptance, cmd_addr, cmd_write and cmd_wdata are captured.
  - If cmd_addr[1:0] != 0, go to RESP with rsp_err = 1 and rsp_rdata = ERR_DATA. No AXI activity occurs.
  - Otherwise a write goes to WR_REQ and a read goes to RD_REQ.
- WR_REQ: AWVALID and WVALID rise together on the cycle after acceptance. AWADDR and WDATA are held stable while their VALID is high.
  - Each VALID drops on the cycle after its own handshake (VALID && READY sampled high).
  - When both handshakes are done, go to WR_RESP. If both complete in the same cycle, go there directly.
- WR_RESP: BREADY = 1. On BVALID, go to RESP with rsp_err = 0 and rsp_rdata = 0. BREADY drops on the next cycle.
- RD_REQ: ARVALID = 1 with ARADDR held stable. On the ARREADY handshake, go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA into rsp_rdata, set rsp_err = 0 and go to RESP.
- RESP: rsp_valid = 1 and the response is held stable until rsp_ready. On rsp_ready, go to IDLE; cmd_ready = 1 on the following cycle. Throughput is one transaction per (AXI latency + 2) cycles.
- Timeout: an 8-bit counter clears on entry to each of WR_REQ, WR_RESP, RD_REQ and RD_DATA and increments every cycle spent in that state.
  - When the counter reaches TIMEOUT_CYCLES-1 without the exit condition, all AXI VALID and READY outputs deassert on the next edge. The block then goes to RESP with rsp_err = 1 and rsp_rdata = ERR_DATA.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Expected latency against axi_slave for a write (cycle 0 = command accepted):
  - AWVALID/WVALID high at cycle 1.
  - AWREADY/WREADY handshake at cycle 2.
  - BVALID handshake at cycle 3.
  - rsp_valid at cycle 4.
- Expected latency against axi_slave for a read: ARVALID at cycle 1, ARREADY at cycle 2, RVALID at cycle 3, rsp_valid at cycle 4.
- Stray BVALID or RVALID outside WR_RESP / RD_DATA is ignored; BREADY and RREADY remain 0.

Test Plan:
- Write cmd_addr=0x10, cmd_wdata=0xA5A5_0001 into axi_slave -> AWADDR=0x10 with AWVALID/WVALID high at cycle 1, BREADY handshake at cycle 3, rsp_valid at cycle 4 with rsp_err=0, rsp_rdata=0.
- Read back from 0x10 after that write -> ARVALID at cycle 1, rsp_valid at cycle 4 with rsp_rdata=0xA5A5_0001, rsp_err=0.
- cmd_addr=0x13 (misaligned) -> no AW/AR activity, rsp_valid on the cycle after acceptance with rsp_err=1, rsp_rdata=0xDEAD_BEEF.
- Slave model tied AWREADY=1 cycle early and WREADY=3 cycles late -> AWVALID drops after its handshake, WVALID stays high until its own handshake, exactly one BREADY handshake follows.
- Slave never asserts RVALID with TIMEOUT_CYCLES=16 -> RREADY drops after 16 cycles in RD_DATA, rsp_err=1, rsp_rdata=0xDEAD_BEEF, and the next command is accepted normally.
- ARESETn pulsed low while in WR_RESP, plus rsp_ready held low for 5 cycles in RESP -> after reset all outputs are 0 and no response is issued; in the stall case the response is held stable for 5 cycles and cmd_ready stays 0 throughout.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - AXI4-lite single-outstanding master for a command/response interface
//
// Serialises one command at a time onto AXI-lite AW/W/B or AR/R, rejects
// misaligned addresses without touching the bus, and aborts any AXI wait
// state that lasts TIMEOUT_CYCLES cycles.
//
// Ports:
//   ACLK, ARESETn                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_write, cmd_addr, cmd_wdata    command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_err                response payload
//   AW*, W*, B*                       AXI-lite write channels
//   AR*, R*                           AXI-lite read channels

module axi_lite_cmd_master #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RVALID,
    output logic              RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RESP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [ADDR_W-1:0]   r_awaddr;
    logic                r_awvalid;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wvalid;
    logic                r_bready;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;

    // Inside WR_REQ a VALID that is already low has finished its handshake,
    // so a channel is done when its VALID is low or it is handshaking now.
    logic w_aw_done;
    logic w_w_done;
    logic w_tmo;

    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wvalid  || WREADY;
    assign w_tmo     = (r_cnt == TO_LAST);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_cnt       <= '0;
                        if (cmd_addr[1:0] != 2'b00) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= ERR_DATA;
                            r_state     <= S_RESP;
                        end else if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_cnt    <= '0;
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end else if (w_tmo) begin
                        r_awvalid   <= 1'b0;
                        r_wvalid    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= ERR_DATA;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= ERR_DATA;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RD_REQ: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RD_DATA;
                    end else if (w_tmo) begin
                        r_arvalid   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= ERR_DATA;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RD_DATA: begin
                    if (RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= RDATA;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= ERR_DATA;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign AWADDR    = r_awaddr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_araddr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - self-checking bench for axi_lite_cmd_master

module tb_axi_lite_cmd_master;

    localparam int          T     = 16;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;

    axi_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int cyc;
    initial begin
        cyc = 0;
        forever begin
            @(posedge ACLK);
            cyc++;
        end
    end

    // Expected behaviour of the transaction in flight, in cycles relative to acceptance
    bit          tx_active;
    int          acc_cyc;
    int          m_aw_s, m_aw_e, m_w_s, m_w_e, m_b_s, m_b_e;
    int          m_ar_s, m_ar_e, m_r_s, m_r_e, m_rs, m_re, m_bexp;
    logic [31:0] m_addr, m_wdata, m_data;
    bit          m_err;
    int          lit_rs;
    logic [31:0] lit_dat;
    logic [31:0] exp_mem [logic [31:0]];

    // Slave configuration: READY delay in cycles after VALID (-1 = READY held high), NEVER = stall
    int s_awd, s_wd, s_bd, s_ard, s_rd, s_gen;

    int          n_cmp, n_fail;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic in_w(int rc, int s, int e);
        return (rc >= s) && (rc <= e);
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Slave model: acts half a cycle after the DUT, so its outputs are settled well before each posedge
    int          sl_gen, aw_cnt, w_cnt, ar_cnt, b_wait, r_wait, b_count;
    bit          p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, b_arm, r_arm;
    logic [31:0] aw_a, w_d, ar_a;
    logic [31:0] smem [logic [31:0]];

    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RDATA = '0;
        sl_gen = -1; b_count = 0;
        forever begin
            @(negedge ACLK);
            #1;
            if (sl_gen != s_gen) begin
                sl_gen = s_gen;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0; b_count = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
                aw_got = 0; w_got = 0; b_arm = 0; r_arm = 0;
                BVALID = 0; RVALID = 0;
            end
            if (p_aw) aw_got = 1;
            if (p_w) w_got = 1;
            if (p_b) begin BVALID = 0; b_count++; end
            if (p_ar) begin
                RDATA = smem.exists(ar_a) ? smem[ar_a] : 32'h0;
                r_arm = 1; r_wait = s_rd;
            end
            if (p_r) RVALID = 0;
            if (aw_got && w_got) begin
                smem[aw_a] = w_d;
                aw_got = 0; w_got = 0; b_arm = 1; b_wait = s_bd;
            end
            if (b_arm && s_bd < NEVER) begin
                if (b_wait == 0) begin BVALID = 1; b_arm = 0; end
                else b_wait--;
            end
            if (r_arm && s_rd < NEVER) begin
                if (r_wait == 0) begin RVALID = 1; r_arm = 0; end
                else r_wait--;
            end
            aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
            w_cnt   = WVALID  ? w_cnt + 1  : 0;
            ar_cnt  = ARVALID ? ar_cnt + 1 : 0;
            AWREADY = (s_awd < 0) || (AWVALID && aw_cnt > s_awd);
            WREADY  = (s_wd < 0)  || (WVALID  && w_cnt  > s_wd);
            ARREADY = (s_ard < 0) || (ARVALID && ar_cnt > s_ard);
            p_aw = AWVALID && AWREADY; if (p_aw) aw_a = AWADDR;
            p_w  = WVALID && WREADY;   if (p_w)  w_d  = WDATA;
            p_ar = ARVALID && ARREADY; if (p_ar) ar_a = ARADDR;
            p_b  = BVALID && BREADY;
            p_r  = RVALID && RREADY;
        end
    end

    // Compare process: checks every DUT output against the model once per cycle
    int rc, since_rst;
    initial begin
        since_rst = 0;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                since_rst = 0;
                check("reset_outputs_zero",
                      32'(|{cmd_ready, rsp_valid, rsp_err, rsp_rdata, AWADDR, AWVALID, WDATA,
                            WVALID, BREADY, ARADDR, ARVALID, RREADY}), 32'h0);
            end else begin
                since_rst++;
                if (since_rst == 1) check("cmd_ready_after_reset", cmd_ready, 1);
                if (tx_active) begin
                    rc = cyc - acc_cyc;
                    check("cmd_ready", cmd_ready, (rc > m_re) ? 1 : 0);
                    check("awvalid", AWVALID, in_w(rc, m_aw_s, m_aw_e));
                    check("wvalid", WVALID, in_w(rc, m_w_s, m_w_e));
                    check("bready", BREADY, in_w(rc, m_b_s, m_b_e));
                    check("arvalid", ARVALID, in_w(rc, m_ar_s, m_ar_e));
                    check("rready", RREADY, in_w(rc, m_r_s, m_r_e));
                    check("rsp_valid", rsp_valid, in_w(rc, m_rs, m_re));
                    if (AWVALID) check("awaddr", AWADDR, m_addr);
                    if (WVALID)  check("wdata", WDATA, m_wdata);
                    if (ARVALID) check("araddr", ARADDR, m_addr);
                    if (rsp_valid) begin
                        check("rsp_err", rsp_err, m_err);
                        check("rsp_rdata", rsp_rdata, m_data);
                    end
                    if (rc == lit_rs) begin
                        check("lit_rsp_valid", rsp_valid, 1);
                        check("lit_rsp_rdata", rsp_rdata, lit_dat);
                    end
                    if (rc == m_re + 1) check("b_handshakes", b_count, m_bexp);
                end else begin
                    check("idle_quiet", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}), 32'h0);
                end
            end
        end
    end

    task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int awd, input int wd, input int bd, input int ard, input int rd,
                       input int stall, input int rst_at, input int l_rs, input logic [31:0] l_dat);
        int n, aw_hs, w_hs, hw, ha;
        logic [1:0] lo;
        @(negedge ACLK);
        s_awd = awd; s_wd = wd; s_bd = bd; s_ard = ard; s_rd = rd; s_gen++;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready) begin
            @(negedge ACLK);
            n++;
            if (n > 20) begin
                $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", n);
                $fatal(1, "command not accepted");
            end
        end
        // Model: windows and response derived from handshake times and the timeout rule
        m_aw_s = 1; m_aw_e = 0; m_w_s = 1; m_w_e = 0; m_b_s = 1; m_b_e = 0;
        m_ar_s = 1; m_ar_e = 0; m_r_s = 1; m_r_e = 0;
        m_addr = addr; m_wdata = wdata; m_err = 1; m_data = ERR;
        lo = addr[1:0];
        if (lo != 2'b00) begin
            m_rs = 1;
        end else if (wr) begin
            aw_hs = 1 + imax(awd, 0);
            w_hs  = 1 + imax(wd, 0);
            hw    = imax(aw_hs, w_hs);
            m_aw_e = imin(aw_hs, T);
            m_w_e  = imin(w_hs, T);
            if (hw > T) begin
                m_rs = T + 1;
            end else if (bd + 1 <= T) begin
                m_b_s = hw + 1; m_b_e = hw + 1 + bd; m_rs = hw + 2 + bd;
                m_err = 0; m_data = 32'h0;
            end else begin
                m_b_s = hw + 1; m_b_e = hw + T; m_rs = hw + 1 + T;
            end
        end else begin
            ha = 1 + imax(ard, 0);
            m_ar_e = imin(ha, T);
            if (ha > T) begin
                m_rs = T + 1;
            end else if (rd + 1 <= T) begin
                m_r_s = ha + 1; m_r_e = ha + 1 + rd; m_rs = ha + 2 + rd;
                m_err = 0; m_data = exp_mem.exists(addr) ? exp_mem[addr] : 32'h0;
            end else begin
                m_r_s = ha + 1; m_r_e = ha + T; m_rs = ha + 1 + T;
            end
        end
        m_re   = m_rs + stall;
        m_bexp = (wr && !m_err) ? 1 : 0;
        lit_rs = l_rs; lit_dat = l_dat;
        acc_cyc = cyc;
        tx_active = 1;
        @(negedge ACLK);
        cmd_valid = 0;
        if (rst_at > 0) begin
            while (cyc < acc_cyc + rst_at) @(negedge ACLK);
            ARESETn = 0;
            tx_active = 0;
            repeat (2) @(negedge ACLK);
            ARESETn = 1;
            repeat (2) @(negedge ACLK);
        end else begin
            while (cyc < acc_cyc + m_re) @(negedge ACLK);
            rsp_ready = 1;
            @(negedge ACLK);
            rsp_ready = 0;
            tx_active = 0;
            if (wr && !m_err) exp_mem[addr] = wdata;
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; tx_active = 0; acc_cyc = 0; lit_rs = -1; lit_dat = '0;
        s_awd = 1; s_wd = 1; s_bd = 0; s_ard = 1; s_rd = 0; s_gen = 0;
        ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1;
        repeat (2) @(negedge ACLK);
        //   wr addr          wdata          awd    wd     bd     ard rd     stall rst lit_rs lit_dat
        run(1, 32'h10, 32'hA5A5_0001,  1,     1,     0,     0,  0,     0,    0,  4,     32'h0);
        run(0, 32'h10, 32'h0,          0,     0,     0,     1,  0,     0,    0,  4,     32'hA5A5_0001);
        run(0, 32'h13, 32'h0,          1,     1,     0,     1,  0,     0,    0,  1,     ERR);
        run(1, 32'h22, 32'h1111_2222,  1,     1,     0,     1,  0,     0,    0,  1,     ERR);
        run(1, 32'h20, 32'h1234_5678, -1,     3,     0,     0,  0,     0,    0,  6,     32'h0);
        run(0, 32'h20, 32'h0,          0,     0,     0,     0,  2,     0,    0,  5,     32'h1234_5678);
        run(0, 32'h30, 32'h0,          0,     0,     0,     1,  NEVER, 0,    0,  19,    ERR);
        run(0, 32'h10, 32'h0,          0,     0,     0,     1,  0,     0,    0,  4,     32'hA5A5_0001);
        run(0, 32'h20, 32'h0,          0,     0,     0,     1,  15,    0,    0,  19,    32'h1234_5678);
        run(1, 32'h40, 32'hCAFE_F00D,  1,     1,     0,     0,  0,     5,    0,  9,     32'h0);
        run(1, 32'h44, 32'h0BAD_0BAD,  0,     NEVER, 0,     0,  0,     0,    0,  17,    ERR);
        run(1, 32'h48, 32'h5555_AAAA,  1,     1,     NEVER, 0,  0,     0,    3,  -1,    32'h0);
        run(0, 32'h40, 32'h0,          0,     0,     0,     1,  0,     0,    0,  4,     32'hCAFE_F00D);
        repeat (3) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
